// File: rtl/xdisplay_ctrl.sv
// xdisplay_ctrl: 4-register bus responder plus a time-multiplexed common-anode
// 7-segment scan driver with blanking at the start of each digit slot.
module xdisplay_ctrl #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel,
  input  logic                we,
  input  logic [1:0]          addr,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [N_DIGITS-1:0] an_n
);

  localparam int unsigned VAL_W   = 4 * N_DIGITS;
  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_BLANK = PRESC_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_DIGITS - 1);

  localparam logic [1:0] A_VALUE  = 2'd0;
  localparam logic [1:0] A_DP     = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  // Hex digit to active-high segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Register bank
  logic [VAL_W-1:0]    value_q, value_d;
  logic [N_DIGITS-1:0] dp_q, dp_d;
  logic                en_q, en_d;
  logic [N_DIGITS-1:0] mask_q, mask_d;

  // Scan state
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         frame_q, frame_d;

  // Registered outputs
  logic [31:0]         data_out_q, data_out_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic                dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;

  logic                wr_c;
  logic                rd_c;
  logic                run_c;
  logic                blank_c;
  logic [3:0]          nib_c;
  logic [31:0]         rdata_c;
  logic                unused_c;

  assign wr_c     = sel & we;
  assign rd_c     = sel & ~we;
  assign unused_c = ^data_in;

  // Bus writes into the register bank; STATUS and unused bits are not writable.
  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    en_d    = en_q;
    mask_d  = mask_q;
    if (wr_c) begin
      case (addr)
        A_VALUE: value_d = data_in[VAL_W-1:0];
        A_DP:    dp_d    = data_in[N_DIGITS-1:0];
        A_CTRL: begin
          en_d   = data_in[0];
          mask_d = data_in[8 +: N_DIGITS];
        end
        default: ;
      endcase
    end
  end

  // Scan counters advance only while EN is set both before and after this edge,
  // so an enable restarts from slot 0 and a disable parks the scan immediately.
  always_comb begin
    run_c   = en_q & en_d;
    presc_d = presc_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    if (!run_c) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        frame_d = frame_q + 16'd1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Read mux over pre-edge register state; idle cycles return zero.
  always_comb begin
    rdata_c = '0;
    case (addr)
      A_VALUE:  rdata_c = 32'(value_q);
      A_DP:     rdata_c = 32'(dp_q);
      A_CTRL:   rdata_c = 32'({mask_q, 7'b0, en_q});
      A_STATUS: rdata_c = {8'(idx_q), 8'h00, frame_q};
      default:  rdata_c = '0;
    endcase
    data_out_d = rd_c ? rdata_c : 32'h0;
  end

  // Display drive for the current slot; anodes stay dark during the blank window.
  always_comb begin
    blank_c = (presc_q < PRESC_BLANK);
    nib_c   = 4'(value_q >> {idx_q, 2'b00});
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (en_q) begin
      seg_n_d = ~hex7(nib_c);
      dp_n_d  = ~dp_q[idx_q];
      if (!blank_c && mask_q[idx_q]) begin
        an_n_d = ~(N_DIGITS'(1) << idx_q);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= '0;
      dp_q       <= '0;
      en_q       <= 1'b0;
      mask_q     <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      data_out_q <= '0;
      seg_n_q    <= 7'h7F;
      dp_n_q     <= 1'b1;
      an_n_q     <= '1;
    end else begin
      value_q    <= value_d;
      dp_q       <= dp_d;
      en_q       <= en_d;
      mask_q     <= mask_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      data_out_q <= data_out_d;
      seg_n_q    <= seg_n_d;
      dp_n_q     <= dp_n_d;
      an_n_q     <= an_n_d;
    end
  end

  assign data_out = data_out_q;
  assign seg_n    = seg_n_q;
  assign dp_n     = dp_n_q;
  assign an_n     = an_n_q;

endmodule
